// File: rtl/motion_pkg.sv
// Shared encodings for the motion engine: direction codes, FSM states, helpers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package motion_pkg;

    localparam int SPEED_W = 3;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_LEFT  = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MOVE    = 2'd1,
        ST_BLOCKED = 2'd2
    } state_t;

    // Opposite direction: flipping bit 1 swaps up<->down and right<->left.
    function automatic dir_t dir_reverse(input dir_t d);
        return dir_t'({~d[1], d[0]});
    endfunction

endpackage

// File: rtl/step_divider.sv
// Tick divider: counts ticks and flags a step opportunity every speed+1 ticks.
// Latency: opportunity is combinational in the tick cycle; counter updates on that edge.
// Backpressure: none; clear dominates and holds the count at 0.
module step_divider
    import motion_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_resetn,
    input  logic               i_clr,
    input  logic               i_en,
    input  logic [SPEED_W-1:0] i_speed,
    output logic               o_opp
);

    logic [SPEED_W-1:0] r_cnt;

    // A changed speed never clears the count: a count above speed wraps through 7.
    assign o_opp = i_en && !i_clr && (r_cnt == i_speed);

    // Divider counter: clear, restart on opportunity, otherwise count ticks.
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= o_opp ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/motion_engine.sv
// Moves a point one unit per step opportunity inside a bounded field, bouncing or stopping at walls.
// Latency: x/y/step/hit_wall register on the edge consuming the opportunity tick (1 clock).
// Backpressure: none; direction requests are latched as a single overwriting pending slot.
module motion_engine
    import motion_pkg::*;
#(
    parameter int XW     = 7,
    parameter int YW     = 7,
    parameter int XMAX   = 124,
    parameter int YMAX   = 92,
    parameter int X_INIT = 0,
    parameter int Y_INIT = 0
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               enable,
    input  logic               tick,
    input  logic [SPEED_W-1:0] speed,
    input  logic               mode,
    input  logic [1:0]         dir_req,
    input  logic               dir_req_valid,
    output logic [XW-1:0]      x,
    output logic [YW-1:0]      y,
    output logic [1:0]         dir,
    output logic               moving,
    output logic               step,
    output logic               hit_wall
);

    localparam logic [XW-1:0] XMAX_L   = XW'(XMAX);
    localparam logic [YW-1:0] YMAX_L   = YW'(YMAX);
    localparam logic [XW-1:0] X_INIT_L = XW'(X_INIT);
    localparam logic [YW-1:0] Y_INIT_L = YW'(Y_INIT);

    state_t          r_state;
    logic [XW-1:0]   r_x;
    logic [YW-1:0]   r_y;
    dir_t            r_dir;
    logic            r_pend_vld;
    dir_t            r_pend_dir;
    logic            r_step;
    logic            r_hit;

    state_t          w_state_nxt;
    logic [XW-1:0]   w_x_nxt;
    logic [YW-1:0]   w_y_nxt;
    dir_t            w_dir_nxt;
    logic            w_step_nxt;
    logic            w_hit_nxt;
    logic            w_div_clr;
    logic            w_opp;
    logic            w_blk_tick;
    logic            w_apply;
    dir_t            w_eff_dir;
    logic            w_at_wall;

    // Divider only runs while actively moving; any other state pins it at 0.
    assign w_div_clr  = (r_state != ST_MOVE) || !enable;
    assign w_blk_tick = (r_state == ST_BLOCKED) && enable && tick;
    assign w_apply    = w_opp || w_blk_tick;
    // A request posted in this cycle is not yet visible here, so it waits for the next opportunity.
    assign w_eff_dir  = r_pend_vld ? r_pend_dir : r_dir;

    step_divider u_div (
        .i_clk    (clk),
        .i_resetn (resetn),
        .i_clr    (w_div_clr),
        .i_en     (tick),
        .i_speed  (speed),
        .o_opp    (w_opp)
    );

    // Is the effective direction pointing into the boundary at the current position?
    always_comb begin
        w_at_wall = 1'b0;
        case (w_eff_dir)
            DIR_UP:    w_at_wall = (r_y == '0);
            DIR_RIGHT: w_at_wall = (r_x == XMAX_L);
            DIR_DOWN:  w_at_wall = (r_y == YMAX_L);
            DIR_LEFT:  w_at_wall = (r_x == '0);
            default:   w_at_wall = 1'b0;
        endcase
    end

    // Next-state and datapath decode.
    always_comb begin
        w_state_nxt = r_state;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        w_dir_nxt   = r_dir;
        w_step_nxt  = 1'b0;
        w_hit_nxt   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (enable) begin
                    w_state_nxt = ST_MOVE;
                end
            end
            ST_MOVE: begin
                if (!enable) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_opp) begin
                    if (w_at_wall) begin
                        w_hit_nxt = 1'b1;
                        if (mode) begin
                            w_dir_nxt   = w_eff_dir;
                            w_state_nxt = ST_BLOCKED;
                        end else begin
                            w_dir_nxt = dir_reverse(w_eff_dir);
                        end
                    end else begin
                        w_dir_nxt  = w_eff_dir;
                        w_step_nxt = 1'b1;
                        case (w_eff_dir)
                            DIR_UP:    w_y_nxt = r_y - 1'b1;
                            DIR_RIGHT: w_x_nxt = r_x + 1'b1;
                            DIR_DOWN:  w_y_nxt = r_y + 1'b1;
                            DIR_LEFT:  w_x_nxt = r_x - 1'b1;
                            default:   w_x_nxt = r_x;
                        endcase
                    end
                end
            end
            ST_BLOCKED: begin
                if (!enable) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_blk_tick && r_pend_vld) begin
                    // A new heading away from the wall releases the block; no move this tick.
                    w_dir_nxt = w_eff_dir;
                    if (!w_at_wall) begin
                        w_state_nxt = ST_MOVE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Position, direction and pulse registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_x    <= X_INIT_L;
            r_y    <= Y_INIT_L;
            r_dir  <= DIR_RIGHT;
            r_step <= 1'b0;
            r_hit  <= 1'b0;
        end else begin
            r_x    <= w_x_nxt;
            r_y    <= w_y_nxt;
            r_dir  <= w_dir_nxt;
            r_step <= w_step_nxt;
            r_hit  <= w_hit_nxt;
        end
    end

    // Pending direction slot: a new post wins over clearing on use.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_pend_vld <= 1'b0;
            r_pend_dir <= DIR_RIGHT;
        end else if (dir_req_valid) begin
            r_pend_vld <= 1'b1;
            r_pend_dir <= dir_t'(dir_req);
        end else if (w_apply) begin
            r_pend_vld <= 1'b0;
        end
    end

    assign x        = r_x;
    assign y        = r_y;
    assign dir      = r_dir;
    assign moving   = (r_state == ST_MOVE);
    assign step     = r_step;
    assign hit_wall = r_hit;

endmodule
